// File: rtl/dpram_arb_pkg.sv
// Shared defaults and helpers for the dual-port RAM arbiter.
// Sized for the 16x8 dual_port_ram with four requesters.
package dpram_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;

    // Requester ID width; a single requester still needs one bit
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dual_port_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester found at or after ptr wins.
// Produces a one-hot grant, an any-grant flag and the winner index.
module rr_arbiter import dpram_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any_gnt,
    output logic [ID_W-1:0]    idx
);

    // Scan from ptr with wraparound and stop at the first set request
    always_comb begin
        int k;
        gnt     = '0;
        any_gnt = 1'b0;
        idx     = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any_gnt && req[k]) begin
                gnt[k]  = 1'b1;
                any_gnt = 1'b1;
                idx     = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Shares a dual-port RAM: writes go to port 0, reads to port 1,
// each with its own round-robin pointer; read data is tagged by ID.
module dual_port_ram_arbiter import dpram_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      ram_wr_en,
    output logic                      ram_port_en_0,
    output logic [ADDR_W-1:0]         ram_addr_in_0,
    output logic [DATA_W-1:0]         ram_data_in,
    output logic                      ram_port_en_1,
    output logic [ADDR_W-1:0]         ram_addr_in_1,
    input  logic [DATA_W-1:0]         ram_data_out_1
);

    logic [NUM_REQ-1:0] wr_cand, rd_cand;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
    logic               wr_any, rd_any;
    logic               wr_go, rd_go, collide;
    logic [ID_W-1:0]    wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [DATA_W-1:0]  wr_data;

    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign wr_cand = req_valid & req_we;
    assign rd_cand = req_valid & ~req_we;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_wr_arb (
        .req     (wr_cand),
        .ptr     (wr_ptr),
        .gnt     (wr_gnt),
        .any_gnt (wr_any),
        .idx     (wr_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rd_arb (
        .req     (rd_cand),
        .ptr     (rd_ptr),
        .gnt     (rd_gnt),
        .any_gnt (rd_any),
        .idx     (rd_idx)
    );

    // Pick the winners' fields using the one-hot grants
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (wr_gnt[k]) begin
                wr_addr = req_addr[k*ADDR_W +: ADDR_W];
                wr_data = req_wdata[k*DATA_W +: DATA_W];
            end
            if (rd_gnt[k]) begin
                rd_addr = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // A read hitting the address being written waits a cycle for fresh data
    assign collide = wr_any & rd_any & (wr_addr == rd_addr);
    assign wr_go   = rst_n & wr_any;
    assign rd_go   = rst_n & rd_any & ~collide;

    assign req_gnt = (wr_gnt & {NUM_REQ{wr_go}})
                   | (rd_gnt & {NUM_REQ{rd_go}});

    assign ram_wr_en     = wr_go;
    assign ram_port_en_0 = wr_go;
    assign ram_addr_in_0 = wr_go ? wr_addr : '0;
    assign ram_data_in   = wr_go ? wr_data : '0;
    assign ram_port_en_1 = rd_go;
    assign ram_addr_in_1 = rd_go ? rd_addr : '0;
    assign rd_data       = ram_data_out_1;

    // Advance each pointer past its winner only when that port grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) wr_ptr <= nxt(wr_idx);
            if (rd_go) rd_ptr <= nxt(rd_idx);
        end
    end

    // Tag the RAM's registered read data with the granted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) rd_id <= rd_idx;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter with a behavioural 16x8 RAM
// and a transaction-level reference model of both arbiters.
module tb_dual_port_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_gnt;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [7:0]  rd_data;
    logic        ram_wr_en, ram_port_en_0, ram_port_en_1;
    logic [3:0]  ram_addr_in_0, ram_addr_in_1;
    logic [7:0]  ram_data_in, ram_data_out_1;

    dual_port_ram_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_gnt        (req_gnt),
        .rd_valid       (rd_valid),
        .rd_id          (rd_id),
        .rd_data        (rd_data),
        .ram_wr_en      (ram_wr_en),
        .ram_port_en_0  (ram_port_en_0),
        .ram_addr_in_0  (ram_addr_in_0),
        .ram_data_in    (ram_data_in),
        .ram_port_en_1  (ram_port_en_1),
        .ram_addr_in_1  (ram_addr_in_1),
        .ram_data_out_1 (ram_data_out_1)
    );

    always #5 clk = ~clk;

    // Behavioural dual_port_ram: port 0 writes, port 1 registered read
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_port_en_0 && ram_wr_en) ram_mem[ram_addr_in_0] <= ram_data_in;
        if (ram_port_en_1) ram_data_out_1 <= ram_mem[ram_addr_in_1];
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    int         wp = 0;
    int         rp = 0;
    bit         exp_rv = 1'b0;
    int         exp_rid = 0;
    logic [7:0] exp_rdata = '0;
    logic [7:0] mem [16];
    logic [3:0] last_gnt, obs_gnt;
    bit         pend [4];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int k, bit v, bit we, logic [3:0] a, logic [7:0] d);
        req_valid[k]       = v;
        req_we[k]          = we;
        req_addr[k*4 +: 4] = a;
        req_wdata[k*8 +: 8] = d;
    endtask

    // One clock: predict from the model, compare at negedge, then advance
    task automatic cycle();
        logic [3:0] wc, rc, eg, wa, ra;
        logic [7:0] wd;
        int         wi, ri;
        bit         wg, rg;
        @(negedge clk);
        wc = req_valid & req_we;
        rc = req_valid & ~req_we;
        wg = 1'b0; rg = 1'b0; wi = 0; ri = 0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (wp + i) % 4;
            if (!wg && wc[k]) begin wg = 1'b1; wi = k; end
            k = (rp + i) % 4;
            if (!rg && rc[k]) begin rg = 1'b1; ri = k; end
        end
        if (!rst_n) begin wg = 1'b0; rg = 1'b0; end
        wa = req_addr[wi*4 +: 4];
        wd = req_wdata[wi*8 +: 8];
        ra = req_addr[ri*4 +: 4];
        if (wg && rg && wa == ra) rg = 1'b0;
        eg = '0;
        if (wg) eg[wi] = 1'b1;
        if (rg) eg[ri] = 1'b1;
        obs_gnt = req_gnt;
        check("gnt", 32'(req_gnt), 32'(eg));
        check("wr_en", 32'(ram_wr_en), 32'(wg));
        check("port_en_0", 32'(ram_port_en_0), 32'(wg));
        check("addr_in_0", 32'(ram_addr_in_0), wg ? 32'(wa) : 32'd0);
        check("data_in", 32'(ram_data_in), wg ? 32'(wd) : 32'd0);
        check("port_en_1", 32'(ram_port_en_1), 32'(rg));
        check("addr_in_1", 32'(ram_addr_in_1), rg ? 32'(ra) : 32'd0);
        check("rd_valid", 32'(rd_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("rd_id", 32'(rd_id), 32'(exp_rid));
            check("rd_data", 32'(rd_data), 32'(exp_rdata));
        end
        last_gnt = eg;
        @(posedge clk);
        if (!rst_n) begin
            wp = 0; rp = 0; exp_rv = 1'b0;
        end else begin
            exp_rv = rg;
            if (rg) begin exp_rid = ri; exp_rdata = mem[ra]; rp = (ri + 1) % 4; end
            if (wg) begin mem[wa] = wd; wp = (wi + 1) % 4; end
        end
        #1;
    endtask

    initial begin
        logic [3:0] rr_order [6];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset with every requester asking to write
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b1, 4'(k), 8'(k));
        #1;
        cycle();
        check("reset_rd_id", 32'(rd_id), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("first_gnt_req0", 32'(obs_gnt), 32'b0001);

        // Round-robin: fresh pointers, all four writing continuously
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            check("rr_order", 32'(obs_gnt), 32'(rr_order[n]));
        end

        // Fill: requester 1 writes addr+1 to every address
        req_valid = '0;
        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b1, 1'b1, 4'(a), 8'(a + 1));
            cycle();
            check("fill_gnt", 32'(obs_gnt), 32'b0010);
        end
        req_valid = '0;

        // Read return: requester 2 reads address 5
        drive(2, 1'b1, 1'b0, 4'd5, 8'd0);
        cycle();
        check("rd5_gnt", 32'(obs_gnt), 32'b0100);
        req_valid = '0;
        check("rd5_valid", 32'(rd_valid), 32'd1);
        check("rd5_id", 32'(rd_id), 32'd2);
        check("rd5_data", 32'(rd_data), 32'h06);
        cycle();

        // Collision: write AA@3 and read @3 in the same cycle
        drive(0, 1'b1, 1'b1, 4'd3, 8'hAA);
        drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
        cycle();
        check("coll_gnt", 32'(obs_gnt), 32'b0001);
        req_valid[0] = 1'b0;
        cycle();
        check("coll_retry", 32'(obs_gnt), 32'b0010);
        req_valid = '0;
        check("coll_id", 32'(rd_id), 32'd1);
        check("coll_data", 32'(rd_data), 32'hAA);
        cycle();

        // Random traffic with hold-until-grant requesters
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    drive(k, 1'b1, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    pend[k] = 1'b1;
                end
            end
            cycle();
            for (int k = 0; k < 4; k++) begin
                if (last_gnt[k]) begin pend[k] = 1'b0; req_valid[k] = 1'b0; end
            end
        end
        req_valid = '0;
        cycle();
        cycle();

        // Reset asserted inside a read grant cycle drops the read
        drive(2, 1'b1, 1'b0, 4'd7, 8'd0);
        @(negedge clk);
        check("t6_gnt", 32'(req_gnt), 32'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_gnt_rst", 32'(req_gnt), 32'd0);
        check("t6_pen1_rst", 32'(ram_port_en_1), 32'd0);
        @(posedge clk);
        #1;
        wp = 0; rp = 0; exp_rv = 1'b0;
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_rd_id", 32'(rd_id), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b0, 4'(k), 8'd0);
        cycle();
        check("t6_rd_ptr0", 32'(obs_gnt), 32'b0001);
        for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b1, 4'(k + 8), 8'(k));
        cycle();
        check("t6_wr_ptr0", 32'(obs_gnt), 32'b0001);
        req_valid = '0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
